// File: rtl/sd_sector_client_if.sv
// Link between one sector client and the shared sd_card block: mount notifications,
// start vectors with the sector number, and the byte stream in both directions.
interface sd_sector_client_if;
    logic [3:0]  image_mounted;
    logic [31:0] image_size;
    logic [3:0]  rstart;
    logic [3:0]  wstart;
    logic [31:0] rsector;
    logic        rdone;
    logic        outen;
    logic [8:0]  outaddr;
    logic [7:0]  outbyte;
    logic [7:0]  inbyte;

    modport master (
        input  image_mounted, image_size, rdone, outen, outaddr, outbyte,
        output rstart, wstart, rsector, inbyte
    );

    modport slave (
        output image_mounted, image_size, rdone, outen, outaddr, outbyte,
        input  rstart, wstart, rsector, inbyte
    );
endinterface

// File: rtl/sd_sector_client.sv
// Core-side requester for the shared SD sector service, with a private 512-byte buffer.
// Optional request abort after TIMEOUT_CYCLES when SD_CLIENT_TIMEOUT_EN is defined.
module sd_sector_client #(
    parameter int SRC_ID = 0
`ifdef SD_CLIENT_TIMEOUT_EN
    , parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000000
`endif
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_sector,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        present,
    input  logic [8:0]  buf_addr,
    input  logic        buf_we,
    input  logic [7:0]  buf_din,
    output logic [7:0]  buf_dout,
    sd_sector_client_if.master sd
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_FINISH = 2'd2} state_t;

    localparam logic [3:0] SLOT_BIT = 4'b0001 << SRC_ID;

    state_t      r_state, w_state_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        r_err, w_err_nxt;
    logic        r_present, w_present_nxt;
    logic [3:0]  r_rstart, w_rstart_nxt;
    logic [3:0]  r_wstart, w_wstart_nxt;
    logic [31:0] r_rsector, w_rsector_nxt;
    logic [22:0] r_limit, w_limit_nxt;
    logic [7:0]  r_mem [0:511];
    logic [7:0]  r_buf_dout;
    logic [7:0]  r_inbyte;
    logic        w_mount;
    logic        w_req_any;
    logic        w_req_ok;
`ifdef SD_CLIENT_TIMEOUT_EN
    logic [31:0] r_cnt, w_cnt_nxt;
`endif

    assign w_mount   = sd.image_mounted[SRC_ID];
    assign w_req_any = req_rd | req_wr;
    assign w_req_ok  = (req_rd ^ req_wr) && r_present && (req_sector < {9'd0, r_limit});

    // Next-state and next-output logic for the request FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_present_nxt = r_present;
        w_rstart_nxt  = r_rstart;
        w_wstart_nxt  = r_wstart;
        w_rsector_nxt = r_rsector;
        w_limit_nxt   = r_limit;
`ifdef SD_CLIENT_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
`endif
        // A mount in the middle of a transfer must not change whether this transfer is valid
        if (w_mount) begin
            w_limit_nxt = sd.image_size[31:9];
            if (r_state == ST_IDLE) begin
                w_present_nxt = (sd.image_size != 32'd0);
            end else begin
                w_present_nxt = r_present;
            end
        end else begin
            w_limit_nxt = r_limit;
        end
        case (r_state)
            ST_IDLE: begin
                if (w_req_any && w_req_ok) begin
                    w_rsector_nxt = req_sector;
                    if (req_rd) begin
                        w_rstart_nxt = SLOT_BIT;
                    end else begin
                        w_wstart_nxt = SLOT_BIT;
                    end
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_START;
`ifdef SD_CLIENT_TIMEOUT_EN
                    w_cnt_nxt   = 32'd0;
`endif
                end else if (w_req_any) begin
                    w_done_nxt = 1'b1;
                    w_err_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (sd.rdone) begin
                    w_rstart_nxt = 4'd0;
                    w_wstart_nxt = 4'd0;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_FINISH;
                end
`ifdef SD_CLIENT_TIMEOUT_EN
                else if (r_cnt == TIMEOUT_CYCLES - 32'd1) begin
                    w_rstart_nxt = 4'd0;
                    w_wstart_nxt = 4'd0;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
`else
                else begin
                    w_state_nxt = ST_START;
                end
`endif
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_rstart_nxt = 4'd0;
                w_wstart_nxt = 4'd0;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_present <= 1'b0;
            r_rstart  <= 4'd0;
            r_wstart  <= 4'd0;
            r_rsector <= 32'd0;
            r_limit   <= 23'd0;
`ifdef SD_CLIENT_TIMEOUT_EN
            r_cnt     <= 32'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_present <= w_present_nxt;
            r_rstart  <= w_rstart_nxt;
            r_wstart  <= w_wstart_nxt;
            r_rsector <= w_rsector_nxt;
            r_limit   <= w_limit_nxt;
`ifdef SD_CLIENT_TIMEOUT_EN
            r_cnt     <= w_cnt_nxt;
`endif
        end
    end

    // Sector buffer: SD fill owns the write port during a read; core writes only when idle
    always_ff @(posedge clk) begin
        if ((r_state == ST_START) && (r_rstart != 4'd0) && sd.outen) begin
            r_mem[sd.outaddr] <= sd.outbyte;
        end else if (buf_we && !r_busy) begin
            r_mem[buf_addr] <= buf_din;
        end
        r_buf_dout <= r_mem[buf_addr];
        r_inbyte   <= r_mem[sd.outaddr];
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign present    = r_present;
    assign buf_dout   = r_buf_dout;
    assign sd.rstart  = r_rstart;
    assign sd.wstart  = r_wstart;
    assign sd.rsector = r_rsector;
    assign sd.inbyte  = r_inbyte;
endmodule
